// File: rtl/mpu341_pkg.sv
// rtl/mpu341_pkg.sv - shared data-memory widths and arbiter state enumeration
package mpu341_pkg;

    localparam int MPU341_ADDR_W = 4;
    localparam int MPU341_DATA_W = 4;

    typedef enum logic {
        ARB        = 1'b0,
        DBG_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating debug-starvation counter
module arb_starve_ctr (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       inc,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic       at_limit
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Clear wins over increment; the count never moves past the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q != limit)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - core/debug data-memory arbiter; DM_ARB_LOCK_EN adds debug lock state
module dm_arbiter
    import mpu341_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = MPU341_ADDR_W,
    parameter int DATA_W       = MPU341_DATA_W
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              locked
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              at_limit;
    logic              starve_inc;
    logic              starve_clr;

    // Debug waits while it asks and is refused; any grant or a dropped request resets the wait.
    assign starve_inc = dbg_req & ~dbg_gnt;
    assign starve_clr = dbg_gnt | ~dbg_req;

    arb_starve_ctr u_starve_ctr (
        .clk        (clk),
        .sync_reset (sync_reset),
        .inc        (starve_inc),
        .clr        (starve_clr),
        .limit      (LIMIT),
        .at_limit   (at_limit)
    );

    // Grant decision: core by default, debug once starved or when core is idle; lock pins debug.
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!sync_reset) begin
            if (state_q == DBG_LOCKED) begin
                dbg_gnt = dbg_req;
            end else if (core_req && !(at_limit && dbg_req)) begin
                core_gnt = 1'b1;
            end else begin
                dbg_gnt = dbg_req;
            end
        end
    end

    // Shared memory port follows the granted requester; idle cycles present core values as reads.
    always_comb begin
        mem_addr  = dbg_gnt ? dbg_addr  : core_addr;
        mem_wdata = dbg_gnt ? dbg_wdata : core_wdata;
        mem_we    = 1'b0;
        if (core_gnt) begin
            mem_we = core_we;
        end else if (dbg_gnt) begin
            mem_we = dbg_we;
        end
    end

    // Lock state transitions; without the lock feature the arbiter never leaves ARB.
    always_comb begin
        state_d = state_q;
`ifdef DM_ARB_LOCK_EN
        case (state_q)
            ARB:        if (dbg_gnt && dbg_lock) state_d = DBG_LOCKED;
            DBG_LOCKED: if (!dbg_lock) state_d = ARB;
            default:    state_d = ARB;
        endcase
`else
        state_d = ARB;
`endif
    end

`ifdef DM_ARB_LOCK_EN
    assign locked = (state_q == DBG_LOCKED);
`else
    logic unused_dbg_lock;
    assign unused_dbg_lock = dbg_lock;
    assign locked = 1'b0;
`endif

    // Read-return capture: memory answers on the falling edge, so data is ready at the next rising edge.
    always_comb begin
        core_rvalid_d = core_gnt & ~core_we;
        dbg_rvalid_d  = dbg_gnt & ~dbg_we;
        core_rdata_d  = core_rvalid_d ? mem_rdata : core_rdata_q;
        dbg_rdata_d   = dbg_rvalid_d  ? mem_rdata : dbg_rdata_q;
    end

    // State and read-return registers.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q       <= ARB;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            core_rvalid_q <= core_rvalid_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
        end
    end

    // A reset arriving right after a granted read swallows its return strobe.
    assign core_rvalid = core_rvalid_q & ~sync_reset;
    assign dbg_rvalid  = dbg_rvalid_q  & ~sync_reset;
    assign core_rdata  = core_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied debug-request cycles before debug gets priority (range 1..15).
REQ-002 SHALL have parameter ADDR_W, default 4: data-memory address width.
REQ-003 SHALL have parameter DATA_W, default 4: data-memory word width.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port sync_reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports core_req/core_we, input, 1 each: core access request; write when core_we=1.
REQ-007 SHALL have ports core_addr/core_wdata, input, ADDR_W/DATA_W: core address and write data.
REQ-008 SHALL have ports core_gnt/core_rvalid, output, 1 each, and core_rdata, output, DATA_W: grant, read-data valid, read data.
REQ-009 SHALL have ports dbg_req/dbg_we/dbg_lock, input, 1 each: debug request, write, hold-grant request.
REQ-010 SHALL have ports dbg_addr/dbg_wdata, input, ADDR_W/DATA_W, and dbg_gnt/dbg_rvalid (1) and dbg_rdata (DATA_W), output: debug equivalents of the core ports.
REQ-011 SHALL have ports mem_addr/mem_wdata, output, ADDR_W/DATA_W; mem_we, output, 1; mem_rdata, input, DATA_W: shared data-memory port (memory clocked on ~clk).
REQ-012 SHALL have port locked, output, 1: high while debug holds a locked grant.

Function
REQ-013 SHALL grant at most one requester per cycle; core_gnt and dbg_gnt are combinational from the current-cycle requests and state, never both high.
REQ-014 SHALL, in state ARB, grant core when core_req=1 unless starve count equals STARVE_LIMIT; otherwise grant debug when dbg_req=1.
REQ-015 SHALL count debug-waiting cycles (dbg_req=1, dbg_gnt=0), saturating at STARVE_LIMIT; cleared on any dbg_gnt or when dbg_req=0.
REQ-016 SHALL drive mem_addr/mem_wdata from the granted port, and mem_we = granted port's we; with no grant, mem_we=0 and mem_addr/mem_wdata = core values.
REQ-017 SHALL assert <port>_rvalid exactly one cycle after a granted read (we=0), with <port>_rdata = mem_rdata registered at that edge; rdata holds its value otherwise; granted writes produce no rvalid.
REQ-018 SHALL sustain back-to-back grants with one access per cycle, no bubble on requester switch.
REQ-019 SHALL treat simultaneous core_req and dbg_req below the starve limit as a core win; debug is denied and its count increments.

Reset
REQ-020 SHALL, during any cycle with sync_reset=1, force core_gnt=dbg_gnt=mem_we=0, regardless of requests.
REQ-021 SHALL, on a rising edge with sync_reset=1, set state=ARB, starve count=0, core_rvalid=dbg_rvalid=0, core_rdata=dbg_rdata=0, locked=0; a read granted in the preceding cycle produces no rvalid.

Configuration
REQ-022 SHALL, with DM_ARB_LOCK_EN defined, add state DBG_LOCKED: entered at the edge ending a cycle where dbg_gnt=1 and dbg_lock=1; in DBG_LOCKED, dbg_gnt=dbg_req, core_gnt=0, locked=1; exit to ARB at the edge ending a cycle with dbg_lock=0.
REQ-023 SHALL, without DM_ARB_LOCK_EN, ignore dbg_lock, never leave ARB, and tie locked=0; ports remain present.

Structure
REQ-024 SHALL take ADDR_W/DATA_W defaults and the state enumeration (ARB, DBG_LOCKED) from the shared package mpu341_pkg.
REQ-025 SHALL implement the saturating starve counter as sub-module arb_starve_ctr (ports clk, sync_reset, inc, clr, limit, at_limit).

Verification
REQ-026 Core-only read: core_req=1, we=0, addr=3, mem word 3=0xA -> core_gnt same cycle, core_rvalid next cycle, core_rdata=0xA.
REQ-027 Contention: core_req and dbg_req held high, STARVE_LIMIT=4 -> core granted cycles 0-3, debug cycle 4, core cycle 5, pattern repeats.
REQ-028 Debug write then core read: dbg writes 0x5 to addr 7, next cycle core reads addr 7 -> core_rdata=0x5 one cycle later.
REQ-029 Lock (DM_ARB_LOCK_EN): dbg granted with dbg_lock=1 for 3 cycles while core_req=1 -> locked=1, core_gnt=0 throughout; dbg_lock=0 -> core granted next cycle.
REQ-030 Reset mid-access: sync_reset=1 in cycle after a granted read, and with both requests pending -> no rvalid, no grants, mem_we=0, starve count 0; normal arbitration resumes the cycle after reset drops.
